pc_sequencer: RTL

//  Fetch-stage controller: owns the PC register and sequences next-PC selection (sequential, stall, branch, jump).

---
 rtl/pc_sequencer_pkg.sv | 18 +
 rtl/pc_sequencer_branch_target_gen.sv | 24 ++
 rtl/pc_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// The state encoding is part of the debug interface (state_o), so keep the values fixed.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    localparam logic [31:0] PC_STEP = 32'd4;
    localparam int          CNT_W   = 3;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_branch_target_gen.sv
// Combinational redirect-target generation: branch = PC+4 + (imm << 2),
// jump = {PC+4[31:28], idx, 2'b00}.
module branch_target_gen
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] branch_pc4_i,
    input  logic [31:0] branch_imm_i,
    input  logic [31:0] jump_pc4_i,
    input  logic [25:0] jump_idx_i,
    output logic [31:0] branch_tgt_o,
    output logic [31:0] jump_tgt_o
);

    logic [31:0] branch_sum;
    logic        unused_bits;

    // imm[31:30] fall off the top of the shift; the sum wraps modulo 2^32.
    assign branch_sum   = branch_pc4_i + {branch_imm_i[29:0], 2'b00};
    assign branch_tgt_o = align_word(branch_sum);
    assign jump_tgt_o   = {jump_pc4_i[31:28], jump_idx_i, 2'b00};

    assign unused_bits  = ^{branch_imm_i[31:30], jump_pc4_i[27:0]};

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: PC register, next-PC selection, redirect flushes
// and post-redirect fetch bubbles.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        imem_ready_i,
    input  logic        branch_valid_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_pc4_i,
    input  logic [31:0] branch_imm_i,
    input  logic        jump_valid_i,
    input  logic [31:0] jump_pc4_i,
    input  logic [25:0] jump_idx_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        fetch_valid_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        redirect_o,
    output logic [1:0]  state_o
);

    localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYCLES);

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic        active;
    logic        br_take;
    logic        jmp_take;
    logic        hold;

    branch_target_gen u_tgt (
        .branch_pc4_i (branch_pc4_i),
        .branch_imm_i (branch_imm_i),
        .jump_pc4_i   (jump_pc4_i),
        .jump_idx_i   (jump_idx_i),
        .branch_tgt_o (branch_tgt),
        .jump_tgt_o   (jump_tgt)
    );

    // Redirect requests are ignored in BOOT; a taken branch beats a jump and
    // any stall, while a stalled jump waits in ID.
    assign active   = (state_q != ST_BOOT);
    assign br_take  = active && branch_valid_i && branch_taken_i;
    assign jmp_take = active && !br_take && jump_valid_i && !stall_i;
    assign hold     = stall_i || !imem_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;

        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end else if (br_take || jmp_take) begin
            pc_d    = br_take ? branch_tgt : jump_tgt;
            cnt_d   = FLUSH_LD;
            state_d = (FLUSH_LD == '0) ? ST_RUN : ST_REDIRECT;
        end else if (state_q == ST_REDIRECT) begin
            // Bubbles count down regardless of stall; PC holds the new target.
            if (cnt_q <= CNT_W'(1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q - CNT_W'(1);
            end
        end else if (!hold) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_q + PC_STEP;
    assign fetch_valid_o = (state_q == ST_RUN);
    assign flush_if_id_o = br_take || jmp_take;
    assign flush_id_ex_o = br_take;
    assign redirect_o    = br_take || jmp_take;
    assign state_o       = state_q;

endmodule
